// File: rtl/cpu_axi_pkg.sv
// Shared types and constants for the core's AXI read path.
package cpu_axi_pkg;

  // Read-arbiter FSM states
  typedef enum logic [2:0] {
    IDLE,
    AR_I,
    AR_D,
    R_I,
    R_D
  } RdArbState;

  // Master index carried in ARID[0]
  localparam logic MASTER_I = 1'b0;
  localparam logic MASTER_D = 1'b1;

  // AXI burst type encodings
  localparam logic [1:0] INCR = 2'b01;
  localparam logic [1:0] WRAP = 2'b10;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; pointer names the preferred master and
// flips to the loser when a contended grant is taken.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic ptr;

  // Grant: single requester wins outright, contention resolved by ptr
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end
  end

  // Pointer moves to the loser only when a contended grant is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b1;
    end else if (en && (req == 2'b11)) begin
      ptr <= ~ptr;
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI AR/R channel between the ICache (master 0) and DCache
// (master 1). One burst outstanding at a time; grant held until the last
// R beat. Beats are counted against ARLEN and protocol slips set a sticky err.
module axi_rd_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned ID_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  // ICache master
  input  logic              i_arvalid,
  input  logic [ADDR_W-1:0] i_araddr,
  input  logic [LEN_W-1:0]  i_arlen,
  input  logic [2:0]        i_arsize,
  input  logic [1:0]        i_arburst,
  output logic              i_arready,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_rlast,
  output logic [1:0]        i_rresp,
  input  logic              i_rready,
  // DCache master
  input  logic              d_arvalid,
  input  logic [ADDR_W-1:0] d_araddr,
  input  logic [LEN_W-1:0]  d_arlen,
  input  logic [2:0]        d_arsize,
  input  logic [1:0]        d_arburst,
  output logic              d_arready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rlast,
  output logic [1:0]        d_rresp,
  input  logic              d_rready,
  // AXI master side
  output logic              arvalid,
  output logic [ID_W-1:0]   arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [LEN_W-1:0]  arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  input  logic              arready,
  input  logic              rvalid,
  input  logic [ID_W-1:0]   rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rlast,
  input  logic [1:0]        rresp,
  output logic              rready,
  // Status
  output logic              busy,
  output logic              err
);

  import cpu_axi_pkg::*;

  RdArbState         state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W:0]    beat_cnt;  // one extra bit so overrun never wraps to len_q
  logic              err_q;
  logic              arvalid_q;
  logic [ID_W-1:0]   arid_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [LEN_W-1:0]  arlen_q;
  logic [2:0]        arsize_q;
  logic [1:0]        arburst_q;

  logic [1:0]        gnt;
  logic              cur_m;
  logic              r_hs;
  logic              last_expected;

  // Only rid[0] carries routing information
  logic              unused_rid;
  assign unused_rid = ^rid;

  rr_arbiter2 u_rr (
    .clk (clk),
    .rst (rst),
    .req ({d_arvalid, i_arvalid}),
    .en  (state == IDLE),
    .gnt (gnt)
  );

  // Routing and handshake decode from the registered state
  always_comb begin
    cur_m         = (state == AR_D) || (state == R_D);
    rready        = ((state == R_I) && i_rready) || ((state == R_D) && d_rready);
    r_hs          = rvalid && rready;
    last_expected = (beat_cnt == {1'b0, len_q});
    i_arready     = (state == AR_I) && arready;
    d_arready     = (state == AR_D) && arready;
    i_rvalid      = (state == R_I) && rvalid;
    d_rvalid      = (state == R_D) && rvalid;
    i_rdata       = rdata;
    d_rdata       = rdata;
    i_rlast       = rlast;
    d_rlast       = rlast;
    i_rresp       = rresp;
    d_rresp       = rresp;
  end

  assign arvalid = arvalid_q;
  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arlen   = arlen_q;
  assign arsize  = arsize_q;
  assign arburst = arburst_q;
  assign busy    = (state != IDLE);
  assign err     = err_q;

  // Arbitration FSM with registered AR payload, beat counting and error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      len_q     <= '0;
      beat_cnt  <= '0;
      err_q     <= 1'b0;
      arvalid_q <= 1'b0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt[0]) begin
            state     <= AR_I;
            arvalid_q <= 1'b1;
            arid_q    <= ID_W'(MASTER_I);
            araddr_q  <= i_araddr;
            arlen_q   <= i_arlen;
            arsize_q  <= i_arsize;
            arburst_q <= i_arburst;
          end else if (gnt[1]) begin
            state     <= AR_D;
            arvalid_q <= 1'b1;
            arid_q    <= ID_W'(MASTER_D);
            araddr_q  <= d_araddr;
            arlen_q   <= d_arlen;
            arsize_q  <= d_arsize;
            arburst_q <= d_arburst;
          end
        end
        AR_I, AR_D: begin
          // Track the live payload while it is valid; hold the last one if withdrawn
          if (cur_m ? d_arvalid : i_arvalid) begin
            araddr_q  <= cur_m ? d_araddr  : i_araddr;
            arlen_q   <= cur_m ? d_arlen   : i_arlen;
            arsize_q  <= cur_m ? d_arsize  : i_arsize;
            arburst_q <= cur_m ? d_arburst : i_arburst;
          end else begin
            err_q <= 1'b1;
          end
          if (arready) begin
            arvalid_q <= 1'b0;
            len_q     <= arlen_q;
            beat_cnt  <= '0;
            state     <= cur_m ? R_D : R_I;
          end
        end
        R_I, R_D: begin
          if (rvalid && (rid[0] != cur_m)) begin
            err_q <= 1'b1;
          end
          if (r_hs) begin
            if (!(&beat_cnt)) begin
              beat_cnt <= beat_cnt + (LEN_W+1)'(1);
            end
            if (rlast) begin
              state <= IDLE;
              if (!last_expected) err_q <= 1'b1;
            end else if (last_expected) begin
              err_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter.
module tb_axi_rd_arbiter;
  import cpu_axi_pkg::*;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned ID_W   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_arvalid = 0, d_arvalid = 0;
  logic [ADDR_W-1:0] i_araddr = '0, d_araddr = '0;
  logic [LEN_W-1:0]  i_arlen = '0, d_arlen = '0;
  logic [2:0]        i_arsize = '0, d_arsize = '0;
  logic [1:0]        i_arburst = '0, d_arburst = '0;
  logic              i_arready, d_arready;
  logic              i_rvalid, d_rvalid;
  logic [DATA_W-1:0] i_rdata, d_rdata;
  logic              i_rlast, d_rlast;
  logic [1:0]        i_rresp, d_rresp;
  logic              i_rready = 0, d_rready = 0;
  logic              arvalid;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [LEN_W-1:0]  arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arready = 0;
  logic              rvalid = 0;
  logic [ID_W-1:0]   rid = '0;
  logic [DATA_W-1:0] rdata = '0;
  logic              rlast = 0;
  logic [1:0]        rresp = '0;
  logic              rready;
  logic              busy;
  logic              err;

  int n_checks = 0;
  int n_fail   = 0;

  axi_rd_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W),
    .ID_W   (ID_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_arvalid (i_arvalid),
    .i_araddr  (i_araddr),
    .i_arlen   (i_arlen),
    .i_arsize  (i_arsize),
    .i_arburst (i_arburst),
    .i_arready (i_arready),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .i_rlast   (i_rlast),
    .i_rresp   (i_rresp),
    .i_rready  (i_rready),
    .d_arvalid (d_arvalid),
    .d_araddr  (d_araddr),
    .d_arlen   (d_arlen),
    .d_arsize  (d_arsize),
    .d_arburst (d_arburst),
    .d_arready (d_arready),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .d_rlast   (d_rlast),
    .d_rresp   (d_rresp),
    .d_rready  (d_rready),
    .arvalid   (arvalid),
    .arid      (arid),
    .araddr    (araddr),
    .arlen     (arlen),
    .arsize    (arsize),
    .arburst   (arburst),
    .arready   (arready),
    .rvalid    (rvalid),
    .rid       (rid),
    .rdata     (rdata),
    .rlast     (rlast),
    .rresp     (rresp),
    .rready    (rready),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic m, input logic [31:0] addr, input logic [7:0] len);
    if (m) begin
      d_arvalid = 1'b1; d_araddr = addr; d_arlen = len; d_arsize = 3'd2; d_arburst = INCR;
    end else begin
      i_arvalid = 1'b1; i_araddr = addr; i_arlen = len; i_arsize = 3'd2; i_arburst = INCR;
    end
  endtask

  task automatic drop_req(input logic m);
    if (m) d_arvalid = 1'b0;
    else   i_arvalid = 1'b0;
  endtask

  // Called one cycle after the request: the DUT should be presenting AR for m
  task automatic ar_accept(input logic m, input logic [31:0] addr, input logic [7:0] len);
    arready = 1'b1;
    #1;
    check_eq("ar_valid", arvalid, 1'b1);
    check_eq("ar_id", arid, {3'b000, m});
    check_eq("ar_addr", araddr, addr);
    check_eq("ar_len", arlen, len);
    check_eq("ar_size_burst", {arsize, arburst}, {3'd2, INCR});
    check_eq("ar_ready_own", m ? d_arready : i_arready, 1'b1);
    check_eq("ar_ready_other", m ? i_arready : d_arready, 1'b0);
    tick();
    drop_req(m);
    arready = 1'b0;
    #1;
    check_eq("ar_valid_off", arvalid, 1'b0);
    check_eq("busy_in_r", busy, 1'b1);
  endtask

  task automatic r_burst(input logic m, input int n, input int last_at, input logic [ID_W-1:0] id);
    for (int k = 0; k < n; k++) begin
      rvalid = 1'b1;
      rid    = id;
      rdata  = 32'hA500_0000 + (32'(m) << 16) + 32'(k);
      rlast  = (k == last_at);
      rresp  = 2'b00;
      if (m) d_rready = 1'b1;
      else   i_rready = 1'b1;
      #1;
      check_eq("r_valid_own", m ? d_rvalid : i_rvalid, 1'b1);
      check_eq("r_valid_other", m ? i_rvalid : d_rvalid, 1'b0);
      check_eq("r_data", m ? d_rdata : i_rdata, 32'hA500_0000 + (32'(m) << 16) + 32'(k));
      check_eq("r_last", m ? d_rlast : i_rlast, (k == last_at));
      check_eq("r_ready", rready, 1'b1);
      check_eq("r_busy", busy, 1'b1);
      tick();
    end
    rvalid   = 1'b0;
    rlast    = 1'b0;
    i_rready = 1'b0;
    d_rready = 1'b0;
  endtask

  initial begin
    logic m;
    int   h;

    // Reset values
    #3;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_arvalid", arvalid, 1'b0);
    check_eq("rst_ar_payload", {arid, araddr, arlen, arsize, arburst}, '0);
    check_eq("rst_rready", rready, 1'b0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_arready", {i_arready, d_arready}, 2'b00);
    tick();
    rst = 1'b0;
    tick();

    // Single ICache burst of 8 beats
    drive_req(1'b0, 32'h1FC0_0000, 8'd7);
    #1;
    check_eq("lat_no_arvalid_yet", arvalid, 1'b0);
    tick();
    ar_accept(1'b0, 32'h1FC0_0000, 8'd7);
    r_burst(1'b0, 8, 7, 4'd0);
    check_eq("t1_busy_fall", busy, 1'b0);
    check_eq("t1_err", err, 1'b0);

    // Contention: D, I, D, I
    for (int g = 0; g < 4; g++) begin
      m = (g % 2 == 0);
      drive_req(1'b0, 32'h1FC0_1000 + 32'(g), 8'd1);
      drive_req(1'b1, 32'h8000_2000 + 32'(g), 8'd1);
      tick();
      ar_accept(m, m ? 32'h8000_2000 + 32'(g) : 32'h1FC0_1000 + 32'(g), 8'd1);
      r_burst(m, 2, 1, {3'b000, m});
      check_eq("t2_idle_gap", busy, 1'b0);
    end
    drop_req(1'b1);
    drop_req(1'b0);
    check_eq("t2_err", err, 1'b0);

    // Slave stalls arready for 5 cycles
    drive_req(1'b1, 32'h8000_1000, 8'd0);
    tick();
    for (int c = 0; c < 5; c++) begin
      check_eq("t3_stall_valid", arvalid, 1'b1);
      check_eq("t3_stall_addr", araddr, 32'h8000_1000);
      check_eq("t3_stall_len", arlen, 8'd0);
      check_eq("t3_stall_ready", d_arready, 1'b0);
      tick();
    end
    ar_accept(1'b1, 32'h8000_1000, 8'd0);
    r_burst(1'b1, 1, 0, 4'd1);
    check_eq("t3_err", err, 1'b0);

    // Early rlast: arlen=3 ends on beat 2
    drive_req(1'b0, 32'h1000_0040, 8'd3);
    tick();
    ar_accept(1'b0, 32'h1000_0040, 8'd3);
    r_burst(1'b0, 3, 2, 4'd0);
    check_eq("t4_err_set", err, 1'b1);
    check_eq("t4_idle", busy, 1'b0);
    drive_req(1'b1, 32'h2000_0000, 8'd1);
    tick();
    ar_accept(1'b1, 32'h2000_0000, 8'd1);
    r_burst(1'b1, 2, 1, 4'd1);
    check_eq("t4_err_sticky", err, 1'b1);

    // Reset during beat 4 of an 8-beat D burst
    drive_req(1'b1, 32'h3000_0000, 8'd7);
    tick();
    ar_accept(1'b1, 32'h3000_0000, 8'd7);
    r_burst(1'b1, 4, 99, 4'd1);
    rvalid = 1'b1; rid = 4'd1; d_rready = 1'b1; rdata = 32'hDEAD_0004;
    #1;
    check_eq("t5_mid_rready", rready, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("t5_rst_busy", busy, 1'b0);
    check_eq("t5_rst_rready", rready, 1'b0);
    check_eq("t5_rst_drvalid", d_rvalid, 1'b0);
    check_eq("t5_rst_err", err, 1'b0);
    tick();
    check_eq("t5_edge_busy", busy, 1'b0);
    check_eq("t5_edge_arvalid", arvalid, 1'b0);
    rst = 1'b0; rvalid = 1'b0; d_rready = 1'b0;
    drive_req(1'b0, 32'h1FC0_0100, 8'd0);
    #1;
    check_eq("t5_lat", arvalid, 1'b0);
    tick();
    ar_accept(1'b0, 32'h1FC0_0100, 8'd0);
    r_burst(1'b0, 1, 0, 4'd0);
    check_eq("t5_after_busy", busy, 1'b0);
    check_eq("t5_after_err", err, 1'b0);

    // i_rready toggling: count advances only on handshakes
    drive_req(1'b0, 32'h1FC0_0200, 8'd3);
    d_rready = 1'b1;
    tick();
    ar_accept(1'b0, 32'h1FC0_0200, 8'd3);
    h = 0;
    for (int c = 0; c < 7; c++) begin
      rvalid   = 1'b1;
      rid      = 4'd0;
      i_rready = (c % 2 == 0);
      rdata    = 32'hB000_0000 + 32'(h);
      rlast    = (h == 3);
      #1;
      check_eq("t6_rready_mirror", rready, (c % 2 == 0));
      check_eq("t6_rvalid", i_rvalid, 1'b1);
      check_eq("t6_rdata", i_rdata, 32'hB000_0000 + 32'(h));
      check_eq("t6_busy", busy, 1'b1);
      tick();
      if (c % 2 == 0) h++;
    end
    rvalid = 1'b0; rlast = 1'b0; i_rready = 1'b0; d_rready = 1'b0;
    check_eq("t6_done", busy, 1'b0);
    check_eq("t6_count_ok", err, 1'b0);

    // Wrong rid in R_I: still routed to i, err set
    drive_req(1'b0, 32'h1FC0_0300, 8'd0);
    tick();
    ar_accept(1'b0, 32'h1FC0_0300, 8'd0);
    r_burst(1'b0, 1, 0, 4'd1);
    check_eq("t6_rid_err", err, 1'b1);
    check_eq("t6_rid_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares the single AXI read channel (AR/R) between the ICache refill master (port 0) and the DCache refill/uncached-read master (port 1).
- Sits between the IF/MEM cache controllers and the core's AXI master interface.
- Grants one burst at a time, round-robin on contention, and holds the grant until the last R beat.
- Counts beats against ARLEN and flags protocol errors.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, R data width
- LEN_W, 8, ARLEN width (AXI4)
- ID_W, 4, ARID/RID width; master index is placed in ARID[0]

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- i_arvalid, d_arvalid  in  1  per-master read-address request
- i_araddr, d_araddr  in  ADDR_W  per-master address
- i_arlen, d_arlen  in  LEN_W  per-master burst length minus 1
- i_arsize, d_arsize  in  3  per-master beat size
- i_arburst, d_arburst  in  2  per-master burst type
- i_arready, d_arready  out  1  per-master address accept
- i_rvalid, d_rvalid  out  1  per-master routed data valid
- i_rdata, d_rdata  out  DATA_W  routed data
- i_rlast, d_rlast  out  1  routed last
- i_rresp, d_rresp  out  2  routed response
- i_rready, d_rready  in  1  per-master data ready
- arvalid  out  1  AXI AR valid
- arid  out  ID_W  AXI AR id
- araddr  out  ADDR_W  AXI AR address
- arlen  out  LEN_W  AXI AR length
- arsize  out  3  AXI AR size
- arburst  out  2  AXI AR burst
- arready  in  1  AXI AR ready
- rvalid  in  1  AXI R valid
- rid  in  ID_W  AXI R id
- rdata  in  DATA_W  AXI R data
- rlast  in  1  AXI R last
- rresp  in  2  AXI R response
- rready  out  1  AXI R ready
- busy  out  1  a burst is in progress (state is not IDLE)
- err  out  1  sticky protocol error, cleared only by rst

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state=IDLE, rr_ptr=1 (D preferred first), beat_cnt=0, len_q=0, err=0. All valid/ready outputs are 0 and all AR payload outputs are 0.
- States: IDLE, AR_I, AR_D, R_I, R_D.
- IDLE arbitration:
  - Only i requesting -> AR_I. Only d requesting -> AR_D.
  - Both requesting -> the master selected by rr_ptr wins, and rr_ptr flips to the loser.
  - Arbitration is combinational; the transition registers at the next edge.
  - Request-to-arvalid latency is exactly 1 cycle.
- AR_x state:
  - arvalid=1; AR payload is muxed from master x.
  - arid = {zeros, x}, with x=0 for I and x=1 for D.
  - x_arready = arready; the other master's arready is 0.
  - On arvalid&arready: latch len_q=arlen, set beat_cnt=0, go to R_x.
  - Master x must hold arvalid and payload stable. If x_arvalid drops before acceptance, set err and keep driving the last payload, which is registered on entry.
- R_x state:
  - x_rvalid = rvalid, with rdata/rlast/rresp passed through; rready = x_rready.
  - The other master's rvalid is 0. arvalid=0.
  - Each rvalid&rready increments beat_cnt.
  - On a handshake with rlast=1: go to IDLE. If beat_cnt != len_q, set err.
  - On a handshake with rlast=0 and beat_cnt == len_q: set err and stay in R_x until rlast.
  - rid[0] != x on any valid beat: set err; data is still routed to x.
- IDLE and AR states: rready=0, so beats arriving unexpectedly are not accepted.
- Back-to-back bursts: returning to IDLE costs exactly one cycle. A new request seen in that IDLE cycle reaches AR the following cycle.
- Under continuous contention the grant sequence alternates D, I, D, I...
- Only one burst is outstanding at a time; no interleaving.
- rst asserted mid-burst: immediate return to IDLE with all outputs at reset values. Beats still in flight are discarded; the slave is reset on the same signal.
- beat_cnt is LEN_W+1 bits wide to detect overrun without wrap-around.

Decomposition:
- Shared package (cpu_axi_pkg):
  - typedef enum RdArbState {IDLE, AR_I, AR_D, R_I, R_D}
  - constants MASTER_I=0, MASTER_D=1
  - AXI burst encoding INCR=2'b01, WRAP=2'b10
- One natural sub-module, rr_arbiter2: 2-input round-robin grant with pointer update on grant. Everything else stays in one module.

Test Plan:
- i_arvalid only, addr 0x1FC0_0000, arlen=7 -> arvalid on cycle +1 with arid=0; arready=1 -> i_arready pulse; 8 beats routed to i, d_rvalid=0 throughout; busy falls the cycle after the last beat.
- i and d request on the same cycle after reset -> D granted first (arid=1); after its rlast, I granted; repeat both -> order D, I, D, I.
- Slave holds arready=0 for 5 cycles -> arvalid and payload stable for all 5 cycles, then one handshake.
- arlen=3 with rlast asserted on beat 2 -> err=1 and return to IDLE; further traffic proceeds and err stays 1.
- rst pulsed during beat 4 of an 8-beat D burst -> next edge: state IDLE, rready=0, busy=0; a fresh I request is granted normally.
- rid=1 while in R_I, and i_rready toggling 1/0 per cycle -> err=1; rready mirrors i_rready; beat_cnt advances only on handshakes.
